adder_share_arbiter: RTL
========================

Name: adder_share_arbiter

Overview:
- Shares one external 18-bit hybrid carry-lookahead adder instance (four 4-bit CLA blocks plus one 2-bit CLA block) among NUM_REQ requesters.
- Round-robin arbitration on a valid/ready request handshake.
- Drives registered operands to the shared adder, waits one settle cycle, then captures the sum and final carry.
- Returns the result with the winning requester's ID on a valid/ready response channel. Sits between client datapaths and the shared adder.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ID_W, 2, width of resp_id; must equal ceil(log2(NUM_REQ)).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req_valid  input  NUM_REQ  per-requester operation valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_a  input  NUM_REQ*18  operand A, requester i at bits [18*i+17:18*i].
- req_b  input  NUM_REQ*18  operand B, same packing as req_a.
- req_cin  input  NUM_REQ  carry-in per requester.
- add_a  output  18  operand A to the shared adder (registered).
- add_b  output  18  operand B to the shared adder (registered).
- add_cin  output  1  carry-in to the shared adder (registered).
- add_s  input  18  sum from the shared adder.
- add_c  input  5  block carries from the shared adder; add_c[4] is the final carry-out.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts the result.
- resp_id  output  ID_W  index of the requester that owns the result.
- resp_sum  output  18  captured sum.
- resp_cout  output  1  captured final carry-out.

Behaviour:
- Reset: one clock; reset is synchronous and active-low (clk, rst_n). While rst_n=0 at a rising edge:
  - state <= IDLE, rr_ptr <= 0.
  - add_a, add_b, add_cin <= 0.
  - resp_valid, resp_id, resp_sum, resp_cout <= 0.
  - req_ready is 0 throughout reset.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[winner]=1, combinational from state, req_valid and rr_ptr; all other bits 0.
  - No request valid: stay in IDLE, req_ready=0.
  - On handshake (valid and ready both high):
    - latch req_a/req_b/req_cin of the winner into add_a/add_b/add_cin;
    - latch the winner index into id_q;
    - rr_ptr <= (winner+1) mod NUM_REQ;
    - go to ISSUE.
- ISSUE: operands held stable (adder settle cycle); go to CAPTURE.
- CAPTURE:
  - resp_sum <= add_s, resp_cout <= add_c[4], resp_id <= id_q, resp_valid <= 1.
  - Go to RESP.
- RESP:
  - resp_valid=1; resp_sum, resp_cout and resp_id held stable until resp_ready=1.
  - On resp_ready=1: resp_valid <= 0, go to IDLE.
  - req_ready=0 in ISSUE, CAPTURE and RESP.
- Latency and throughput:
  - Request accept at edge N gives resp_valid=1 after edge N+2.
  - With resp_ready tied high, the next accept is at edge N+4, i.e. one op per 4 cycles.
- add_a, add_b and add_cin keep their last values outside ISSUE/CAPTURE; no re-zeroing.
- Arithmetic: unsigned 18-bit; result = {resp_cout, resp_sum} = a + b + cin, range 0..0x7FFFF.
- Requesters:
  - May drop req_valid before being granted; the arbiter re-evaluates every IDLE cycle.
  - Operands are sampled only on the handshake edge.
- Fairness: with continuous requests, no requester waits more than NUM_REQ-1 grants.
- Reset mid-operation: the in-flight op is discarded, no response is issued, and rr_ptr returns to 0.
- Simultaneous rst_n=0 and a handshake: reset wins and nothing is latched.

Optional Feature:
- Macro: SIGNED_OVF_EN.
- Defined:
  - adds output port resp_ovf (1 bit), captured in CAPTURE as two's-complement overflow: (add_a[17]==add_b[17]) && (add_s[17]!=add_a[17]);
  - resp_ovf resets to 0, is held with resp_sum, and is valid only while resp_valid=1.
- Not defined: the port and its logic are absent; everything else is identical.

Test Plan:
- Carry ripple: after reset, req 0 with a=0x3FFFF, b=0x00001, cin=0 → 2 cycles after accept: resp_valid=1, resp_id=0, resp_sum=0x00000, resp_cout=1. Stub adder returns add_c=5'b11111.
- Carry-in path: req 2 with a=0x0FFFF, b=0x00000, cin=1 → resp_sum=0x10000, resp_cout=0, resp_id=2.
- Round robin: all four req_valid high, resp_ready=1 → grant order 0,1,2,3,0; accepts exactly 4 cycles apart.
- Backpressure: hold resp_ready=0 for 6 cycles → resp_valid stays 1 with resp fields stable, req_ready=0 on all bits. Release → next grant after 1 IDLE cycle.
- Reset in CAPTURE: pull rst_n=0 for one cycle while in CAPTURE → no resp_valid pulse; outputs 0; the next grant starts from requester 0.
- SIGNED_OVF_EN: a=0x1FFFF, b=0x00001 → resp_sum=0x20000, resp_ovf=1; a=0x3FFFF, b=0x00001 → resp_ovf=0.

Source files
------------

// File: rtl/adder_share_arbiter_if.sv
// rtl/adder_share_arbiter_if.sv - request, response and shared-adder signals of adder_share_arbiter
// Optional resp_ovf member present only when SIGNED_OVF_EN is defined.
interface adder_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*18-1:0] req_a;
    logic [NUM_REQ*18-1:0] req_b;
    logic [NUM_REQ-1:0]    req_cin;
    logic [17:0]           add_a;
    logic [17:0]           add_b;
    logic                  add_cin;
    logic [17:0]           add_s;
    logic [4:0]            add_c;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [ID_W-1:0]       resp_id;
    logic [17:0]           resp_sum;
    logic                  resp_cout;
`ifdef SIGNED_OVF_EN
    logic                  resp_ovf;
`endif

    modport slave (
        input  req_valid, req_a, req_b, req_cin, add_s, add_c, resp_ready,
        output req_ready, add_a, add_b, add_cin, resp_valid, resp_id, resp_sum, resp_cout
`ifdef SIGNED_OVF_EN
        , output resp_ovf
`endif
    );

    modport master (
        output req_valid, req_a, req_b, req_cin, add_s, add_c, resp_ready,
        input  req_ready, add_a, add_b, add_cin, resp_valid, resp_id, resp_sum, resp_cout
`ifdef SIGNED_OVF_EN
        , input resp_ovf
`endif
    );
endinterface

// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - round-robin sharing of one 18-bit adder among NUM_REQ requesters
// Optional SIGNED_OVF_EN adds a captured two's-complement overflow flag (resp_ovf).
module adder_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adder_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t          state_q;
    logic [ID_W-1:0] rr_ptr_q;
    logic [ID_W-1:0] id_q;
    logic [17:0]     add_a_q;
    logic [17:0]     add_b_q;
    logic            add_cin_q;
    logic            resp_valid_q;
    logic [ID_W-1:0] resp_id_q;
    logic [17:0]     resp_sum_q;
    logic            resp_cout_q;

    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W:0]   pos;
    logic [ID_W-1:0] rr_ptr_d;
    logic            unused_add_c;

    // Scan from farthest to nearest so the closest valid requester to rr_ptr wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        pos         = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (pos >= (ID_W+1)'(NUM_REQ)) begin
                pos = pos - (ID_W+1)'(NUM_REQ);
            end
            if (bus.req_valid[pos[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = pos[ID_W-1:0];
            end
        end
    end

    assign rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        bus.req_ready = '0;
        if (rst_n && state_q == IDLE && grant_found) begin
            bus.req_ready[grant_idx] = 1'b1;
        end
    end

    assign unused_add_c = ^bus.add_c[3:0];

`ifdef SIGNED_OVF_EN
    logic resp_ovf_q;
    assign bus.resp_ovf = resp_ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            id_q         <= '0;
            add_a_q      <= '0;
            add_b_q      <= '0;
            add_cin_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_sum_q   <= '0;
            resp_cout_q  <= 1'b0;
`ifdef SIGNED_OVF_EN
            resp_ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        add_a_q   <= bus.req_a[18*grant_idx +: 18];
                        add_b_q   <= bus.req_b[18*grant_idx +: 18];
                        add_cin_q <= bus.req_cin[grant_idx];
                        id_q      <= grant_idx;
                        rr_ptr_q  <= rr_ptr_d;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: state_q <= CAPTURE;
                CAPTURE: begin
                    resp_sum_q   <= bus.add_s;
                    resp_cout_q  <= bus.add_c[4];
                    resp_id_q    <= id_q;
                    resp_valid_q <= 1'b1;
`ifdef SIGNED_OVF_EN
                    resp_ovf_q   <= (add_a_q[17] == add_b_q[17]) && (bus.add_s[17] != add_a_q[17]);
`endif
                    state_q      <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.add_a      = add_a_q;
    assign bus.add_b      = add_b_q;
    assign bus.add_cin    = add_cin_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_sum   = resp_sum_q;
    assign bus.resp_cout  = resp_cout_q;
endmodule
